// File: rtl/fft_peak_detect_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_detect_if
// Purpose  : Handshake and result bus between the iteration controller
//            (master) and the FFT peak detector (slave).
// Signals  : start      - one-cycle frame start pulse (master -> slave)
//            ready      - detector idle and able to take start (slave -> master)
//            bin_valid  - bin carries a valid FFT bin (master -> slave)
//            bin        - {re[15:0], im[15:0]}, both signed (master -> slave)
//            done       - one-cycle result pulse (slave -> master)
//            peak_idx   - index of strongest positive-frequency bin
//            peak_mag   - re^2 + im^2 of that bin
//            peak_found - a qualifying peak exists
// Revision : 1.0 - initial release
// ============================================================================
interface fft_peak_detect_if #(
  parameter int IDX_W = 8
);
  logic             start;
  logic             ready;
  logic             bin_valid;
  logic [31:0]      bin;
  logic             done;
  logic [IDX_W-1:0] peak_idx;
  logic [31:0]      peak_mag;
  logic             peak_found;

  modport master (
    output start, bin_valid, bin,
    input  ready, done, peak_idx, peak_mag, peak_found
  );

  modport slave (
    input  start, bin_valid, bin,
    output ready, done, peak_idx, peak_mag, peak_found
  );
endinterface
`default_nettype wire

// File: rtl/fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : fft_peak_detect
// Purpose  : Squared-magnitude peak search over one frame of N complex FFT
//            bins. Only bins 1..N/2-1 are candidates; ties keep the lowest
//            index. Two-stage pipeline (square, then sum/compare).
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-low reset
//            bus  - fft_peak_detect_if.slave (start/ready, bin stream, result)
// Options  : PEAK_THRESH_EN - when defined, a peak is reported only if its
//            magnitude exceeds THRESH; otherwise every done reports a peak.
// Revision : 1.0 - initial release
// ============================================================================
module fft_peak_detect #(
  parameter int N     = 256,
  parameter int IDX_W = 8
`ifdef PEAK_THRESH_EN
  ,
  parameter logic [31:0] THRESH = 32'd0
`endif
) (
  input logic               clk,
  input logic               rst,
  fft_peak_detect_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] c_HALF = IDX_W'(N / 2);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [1:0]        r_flush;
  logic              r_ready_en;

  logic              w_accept;
  logic              w_start_run;
  logic              w_enter_done;
  logic              w_ready;
  logic              w_done;

  // Capture register, then stage 1 (squares), then stage 2 (sum/compare).
  logic              r_s0_vld;
  logic signed [15:0] r_s0_re;
  logic signed [15:0] r_s0_im;
  logic [IDX_W-1:0]  r_s0_idx;
  logic              r_s1_vld;
  logic [31:0]       r_s1_re2;
  logic [31:0]       r_s1_im2;
  logic [IDX_W-1:0]  r_s1_idx;

  logic signed [31:0] w_re2;
  logic signed [31:0] w_im2;
  logic [31:0]       w_sum;
  logic              w_cand;

  logic [31:0]       r_best_mag;
  logic [IDX_W-1:0]  r_best_idx;

  logic [IDX_W-1:0]  r_peak_idx;
  logic [31:0]       r_peak_mag;
  logic              r_peak_found;

  assign w_accept     = (r_state == c_RUN) && bus.bin_valid;
  assign w_start_run  = (r_state == c_IDLE) && bus.start;
  // Last compare lands one cycle before this, so best_* is final here.
  assign w_enter_done = (r_state == c_FLUSH) && (r_flush == 2'd2);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (bus.start) w_state_nxt = c_RUN;
      c_RUN:   if (w_accept && (r_cnt == c_LAST)) w_state_nxt = c_FLUSH;
      c_FLUSH: if (r_flush == 2'd2) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. ready stays low until the first edge after reset release.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ready = 1'b0;
    w_done  = 1'b0;
    if (r_state == c_IDLE) w_ready = r_ready_en;
    if (r_state == c_DONE) w_done  = 1'b1;
  end

  assign bus.ready      = w_ready;
  assign bus.done       = w_done;
  assign bus.peak_idx   = r_peak_idx;
  assign bus.peak_mag   = r_peak_mag;
  assign bus.peak_found = r_peak_found;

  // --------------------------------------------------------------------------
  // Bin counter, flush counter and post-reset ready enable.
  // FLUSH spans the capture register and both pipeline stages draining.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_flush    <= 2'd0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_start_run) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == c_FLUSH) begin
        r_flush <= r_flush + 2'd1;
      end else begin
        r_flush <= 2'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline. Bubbles carry vld = 0, so gaps in bin_valid never reach the
  // comparator and the pipe drains on its own during FLUSH.
  // --------------------------------------------------------------------------
  assign w_re2 = r_s0_re * r_s0_re;
  assign w_im2 = r_s0_im * r_s0_im;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s0_vld <= 1'b0;
      r_s0_re  <= '0;
      r_s0_im  <= '0;
      r_s0_idx <= '0;
      r_s1_vld <= 1'b0;
      r_s1_re2 <= '0;
      r_s1_im2 <= '0;
      r_s1_idx <= '0;
    end else begin
      r_s0_vld <= w_accept;
      if (w_accept) begin
        r_s0_re  <= $signed(bus.bin[31:16]);
        r_s0_im  <= $signed(bus.bin[15:0]);
        r_s0_idx <= r_cnt;
      end
      r_s1_vld <= r_s0_vld;
      if (r_s0_vld) begin
        // Squares are non-negative; -32768^2 = 2^30 still fits.
        r_s1_re2 <= $unsigned(w_re2);
        r_s1_im2 <= $unsigned(w_im2);
        r_s1_idx <= r_s0_idx;
      end
    end
  end

  // Sum peaks at 2^31, so 32 bits cannot overflow.
  assign w_sum  = r_s1_re2 + r_s1_im2;
  assign w_cand = (r_s1_idx != '0) && (r_s1_idx < c_HALF);

  // Strict greater-than keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_best_mag <= '0;
      r_best_idx <= '0;
    end else if (w_start_run) begin
      r_best_mag <= '0;
      r_best_idx <= '0;
    end else if (r_s1_vld && w_cand && (w_sum > r_best_mag)) begin
      r_best_mag <= w_sum;
      r_best_idx <= r_s1_idx;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: loaded once per frame, held between done pulses.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_peak_idx   <= '0;
      r_peak_mag   <= '0;
      r_peak_found <= 1'b0;
    end else if (w_enter_done) begin
`ifdef PEAK_THRESH_EN
      if (r_best_mag > THRESH) begin
        r_peak_idx   <= r_best_idx;
        r_peak_mag   <= r_best_mag;
        r_peak_found <= 1'b1;
      end else begin
        r_peak_idx   <= '0;
        r_peak_mag   <= '0;
        r_peak_found <= 1'b0;
      end
`else
      r_peak_idx   <= r_best_idx;
      r_peak_mag   <= r_best_mag;
      r_peak_found <= 1'b1;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fft_peak_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_peak_detect
// Purpose  : Scoreboard bench for fft_peak_detect. The driver builds whole
//            frames, a frame-level reference model pushes the expected result,
//            and a negedge monitor pops and compares on every done pulse.
// Options  : PEAK_THRESH_EN - adds threshold frames (THRESH = 1000).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_peak_detect;

  localparam int N     = 256;
  localparam int IDX_W = 8;
`ifdef PEAK_THRESH_EN
  localparam logic [31:0] THRESH = 32'd1000;
`endif

  typedef struct {
    longint idx;
    longint mag;
    longint found;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.IDX_W(IDX_W)) bus();

  fft_peak_detect #(
    .N     (N),
    .IDX_W (IDX_W)
`ifdef PEAK_THRESH_EN
    ,
    .THRESH(THRESH)
`endif
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          last_cyc = -100;
  bit          last_flag = 1'b0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] frame [N];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  // Reference: max of re^2+im^2 over bins 1..N/2-1, first index wins ties.
  function automatic exp_t model();
    exp_t   e;
    longint best;
    int     bi;
    best = 0;
    bi   = 0;
    for (int i = 1; i < N / 2; i++) begin
      longint re;
      longint im;
      longint m;
      re = longint'($signed(frame[i][31:16]));
      im = longint'($signed(frame[i][15:0]));
      m  = re * re + im * im;
      if (m > best) begin
        best = m;
        bi   = i;
      end
    end
    e.idx   = bi;
    e.mag   = best;
    e.found = 1;
`ifdef PEAK_THRESH_EN
    if (!(best > longint'(THRESH))) begin
      e.idx   = 0;
      e.mag   = 0;
      e.found = 0;
    end
`endif
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    ncyc++;
    if (bus.bin_valid && last_flag) last_cyc = ncyc;
    if (!rst) begin
      check("rst_ready", bus.ready, 0);
      check("rst_done", bus.done, 0);
      check("rst_peak_idx", bus.peak_idx, 0);
      check("rst_peak_mag", bus.peak_mag, 0);
      check("rst_peak_found", bus.peak_found, 0);
    end else if (bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("peak_idx", bus.peak_idx, mon_e.idx);
        check("peak_mag", bus.peak_mag, mon_e.mag);
        check("peak_found", bus.peak_found, mon_e.found);
        // Last bin sampled at this negedge count; done seen 4 negedges later.
        check("done_latency", ncyc - last_cyc, 4);
        check("ready_during_done", bus.ready, 0);
      end
    end
  end

  // Drives one frame from 'frame'. gap_mode: 0 none, 1 every third cycle,
  // 2 random gaps with stray start pulses. abort_after >= 0 resets mid-frame.
  task automatic run_frame(input int gap_mode, input int abort_after);
    int  k;
    int  i;
    int  cyc;
    bit  g;
    @(posedge clk);
    #2;
    k = 0;
    while (!bus.ready && k < 2000) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 required=1 at %0t", $time);
      return;
    end
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    check("ready_in_run", bus.ready, 0);
    if (abort_after < 0) exp_q.push_back(model());
    i   = 0;
    cyc = 0;
    while (i < N) begin
      if (abort_after >= 0 && i == abort_after) begin
        bus.bin_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        return;
      end
      case (gap_mode)
        1:       g = (cyc % 3 == 2);
        2:       g = ($urandom_range(0, 3) == 0);
        default: g = 1'b0;
      endcase
      if (g) begin
        bus.bin_valid = 1'b0;
        last_flag     = 1'b0;
        if (gap_mode == 2 && $urandom_range(0, 1) == 1) bus.start = 1'b1;
      end else begin
        bus.bin_valid = 1'b1;
        bus.bin       = frame[i];
        last_flag     = (i == N - 1);
        i++;
      end
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      cyc++;
    end
    bus.bin_valid = 1'b0;
    last_flag     = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < N; i++) frame[i] = v;
  endtask

  initial begin
    int w;
    bus.start     = 1'b0;
    bus.bin_valid = 1'b0;
    bus.bin       = '0;

    // Reset with bin_valid toggling.
    #1 rst = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #2;
      bus.bin_valid = ~bus.bin_valid;
      bus.bin       = $urandom();
    end
    rst = 1'b1;
    @(negedge clk);
    check("ready_before_first_edge", bus.ready, 0);
    @(negedge clk);
    check("ready_after_release", bus.ready, 1);
    repeat (6) begin
      @(posedge clk);
      #2;
      bus.bin_valid = ~bus.bin_valid;
      bus.bin       = $urandom();
    end
    bus.bin_valid = 1'b0;
    @(negedge clk);
    check("idle_ready", bus.ready, 1);
    check("idle_peak_idx", bus.peak_idx, 0);
    check("idle_peak_mag", bus.peak_mag, 0);
    check("idle_peak_found", bus.peak_found, 0);

    // Single tone.
    fill(pk(1, 1));
    frame[37] = pk(300, -400);
    run_frame(0, -1);

    // DC and upper half ignored.
    fill(pk(0, 0));
    frame[0]   = pk(32767, 0);
    frame[200] = pk(-32768, -32768);
    frame[5]   = pk(10, 0);
    run_frame(0, -1);

    // Tie with gaps.
    fill(pk(0, 0));
    frame[12] = pk(0, 50);
    frame[90] = pk(0, 50);
    run_frame(1, -1);

    // Candidate range edges: 127 is in, 128 is out.
    fill(pk(0, 0));
    frame[1]   = pk(4, 0);
    frame[127] = pk(5, 0);
    frame[128] = pk(100, 0);
    run_frame(0, -1);

    // All-zero frame.
    fill(pk(0, 0));
    run_frame(0, -1);

    // Full-scale candidate.
    fill(pk(0, 0));
    frame[64] = pk(-32768, -32768);
    run_frame(0, -1);

`ifdef PEAK_THRESH_EN
    fill(pk(0, 0));
    frame[7] = pk(30, 0);
    run_frame(0, -1);
    frame[7] = pk(40, 0);
    run_frame(0, -1);
`endif

    // Reset mid-frame, then a clean single-tone frame.
    fill(pk(1, 1));
    frame[37] = pk(300, -400);
    run_frame(0, 100);
    run_frame(0, -1);

    // Randomized frames, back to back.
    for (int f = 0; f < 8; f++) begin
      int mode;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0:       frame[i] = $urandom();
          1:       frame[i] = pk(int'($urandom_range(0, 200)) - 100,
                                 int'($urandom_range(0, 200)) - 100);
          default: begin
            case ($urandom_range(0, 3))
              0:       frame[i] = pk(3, 4);
              1:       frame[i] = pk(-4, 3);
              2:       frame[i] = pk(5, 0);
              default: frame[i] = pk(0, 0);
            endcase
          end
        endcase
      end
      run_frame(int'($urandom_range(0, 2)), -1);
    end

    // Drain outstanding results.
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (5) @(posedge clk);
    check("results_outstanding", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
